snake_turn_queue: RTL and testbench

// Upstream input stage for the snake game core. Cleans the two raw push-buttons
// (sync + debounce), converts each press into a relative turn request (CW/CCW),

---
 rtl/snake_turn_queue.sv | 225 ++++++++++++++++++++++
 tb/tb_snake_turn_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/snake_turn_queue.sv
// snake_turn_queue: synchronises and debounces two push-buttons, queues CW/CCW turns, applies one turn per tick.
// Latency: clean key fall -> queue_count +1 after DEBOUNCE_CYCLES+3 cycles; tick -> direction updates next cycle.
// Backpressure: buttons cannot be stalled; a press arriving at a full queue with no pop is dropped and sets sticky overflow.

// Generic synchronous FIFO with a synchronous flush.
// Latency: a pushed entry is visible at pop_dat the cycle after the push.
// Backpressure: push_rdy is low only when full and no pop is happening in the same cycle.
module fifo_sync #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    input  logic             pop_vld,
    output logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic [PTR_W:0]   count
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             push_fire;
    logic             pop_fire;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
    assign pop_rdy   = (count_q != '0);
    assign pop_fire  = pop_vld && pop_rdy;
    assign push_rdy  = (count_q != FULL_CNT) || pop_fire;
    assign push_fire = push_vld && push_rdy;
    assign pop_dat   = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Occupancy next state: push and pop together leave the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push_fire && !pop_fire) begin
            count_d = count_q + 1'b1;
        end else if (pop_fire && !push_fire) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage, pointers and count; flush empties the queue without touching storage contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_fire) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end
endmodule

module snake_turn_queue #(
    parameter int DEBOUNCE_CYCLES = 252000,
    parameter int QDEPTH          = 4,
    parameter int PTR_W           = 2
) (
    input  logic             VGA_CLK,
    input  logic             RESET,
    input  logic [1:0]       KEY,
    input  logic             enable,
    input  logic             tick,
    output logic [1:0]       direction,
    output logic [PTR_W:0]   queue_count,
    output logic             overflow
);
    // One extra bit so the counter never wraps before reaching its terminal value.
    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Input synchronisers; reset to 1 because the buttons are active-low (released).
    logic [1:0]       key_meta_q;
    logic [1:0]       key_s_q;

    // Per-key debouncer state.
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       stable_q;
    logic [1:0]       stable_d;
    logic [1:0]       press_q;
    logic [1:0]       press_d;

    // Turn application state.
    logic [1:0]       dir_q;
    logic [1:0]       dir_d;
    logic             ovf_q;
    logic             ovf_d;

    // FIFO handshake.
    logic             cw_evt;
    logic             ccw_evt;
    logic             push_vld;
    logic             push_dat;
    logic             push_rdy;
    logic             pop_vld;
    logic             pop_rdy;
    logic             pop_dat;
    logic [PTR_W:0]   fifo_count;

    // Two-flop synchroniser for the raw buttons.
    always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) begin
            key_meta_q <= 2'b11;
            key_s_q    <= 2'b11;
        end else begin
            key_meta_q <= KEY;
            key_s_q    <= key_meta_q;
        end
    end

    // Debounce: count consecutive cycles of disagreement; accept the new level on the last one.
    // The press pulse is raised on the same edge that stable falls, so it is already a register.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            cnt_d[k]    = cnt_q[k];
            stable_d[k] = stable_q[k];
            press_d[k]  = 1'b0;
            if (key_s_q[k] == stable_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_MAX) begin
                stable_d[k] = key_s_q[k];
                cnt_d[k]    = '0;
                press_d[k]  = stable_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    // Debouncer registers; they keep running regardless of enable.
    always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            stable_q <= 2'b11;
            press_q  <= 2'b00;
        end else begin
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    // Simultaneous CW and CCW presses cancel each other and enqueue nothing.
    assign cw_evt   = press_q[0] & ~press_q[1];
    assign ccw_evt  = press_q[1] & ~press_q[0];
    assign push_vld = enable & (cw_evt | ccw_evt);
    assign push_dat = ccw_evt;
    assign pop_vld  = enable & tick;

    fifo_sync #(
        .WIDTH (1),
        .DEPTH (QDEPTH),
        .PTR_W (PTR_W)
    ) u_turn_fifo (
        .clk      (VGA_CLK),
        .rst      (RESET),
        .flush    (~enable),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .push_rdy (push_rdy),
        .pop_vld  (pop_vld),
        .pop_rdy  (pop_rdy),
        .pop_dat  (pop_dat),
        .count    (fifo_count)
    );

    // Heading and sticky overflow next state; disable forces both back to their idle values.
    always_comb begin
        dir_d = dir_q;
        ovf_d = ovf_q;
        if (!enable) begin
            dir_d = 2'd0;
            ovf_d = 1'b0;
        end else begin
            if (pop_vld && pop_rdy) begin
                dir_d = pop_dat ? (dir_q - 2'd1) : (dir_q + 2'd1);
            end
            if (push_vld && !push_rdy) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Heading and overflow registers.
    always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) begin
            dir_q <= 2'd0;
            ovf_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
            ovf_q <= ovf_d;
        end
    end

    assign direction   = dir_q;
    assign queue_count = fifo_count;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_snake_turn_queue.sv
// Directed bench for snake_turn_queue with DEBOUNCE_CYCLES=4, QDEPTH=4.
// A clean press is counted 7 cycles after the key falls; released keys settle within 7 cycles.
module tb_snake_turn_queue;
    logic       VGA_CLK = 1'b0;
    logic       RESET   = 1'b0;
    logic [1:0] KEY     = 2'b11;
    logic       enable  = 1'b1;
    logic       tick    = 1'b0;
    logic [1:0] direction;
    logic [2:0] queue_count;
    logic       overflow;

    int vectors    = 0;
    int miscompares = 0;

    snake_turn_queue #(
        .DEBOUNCE_CYCLES (4),
        .QDEPTH          (4),
        .PTR_W           (2)
    ) dut (
        .VGA_CLK     (VGA_CLK),
        .RESET       (RESET),
        .KEY         (KEY),
        .enable      (enable),
        .tick        (tick),
        .direction   (direction),
        .queue_count (queue_count),
        .overflow    (overflow)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge VGA_CLK);
        #1;
    endtask

    task automatic do_reset();
        KEY = 2'b11; enable = 1'b1; tick = 1'b0;
        RESET = 1'b1;
        step(2);
        RESET = 1'b0;
        step(2);
    endtask

    // Clean press and release of one key.
    task automatic press(input int idx);
        KEY[idx] = 1'b0;
        step(7);
        KEY[idx] = 1'b1;
        step(7);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic test_reset();
        #2 RESET = 1'b1;
        step(2);
        vectors++; if (direction !== 2'd0) begin miscompares++; $display("FAIL reset_dir: got %0d want 0", direction); end
        vectors++; if (queue_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", queue_count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %0d want 0", overflow); end
        RESET = 1'b0;
        step(2);
    endtask

    task automatic test_reset_mid_debounce();
        do_reset();
        press(0); press(0); press(0);
        pulse_tick();
        vectors++; if (queue_count !== 3'd2) begin miscompares++; $display("FAIL t1_pre_count: got %0d want 2", queue_count); end
        vectors++; if (direction !== 2'd1) begin miscompares++; $display("FAIL t1_pre_dir: got %0d want 1", direction); end
        KEY[0] = 1'b0;
        step(3);
        #2 RESET = 1'b1;
        #1;
        vectors++; if (direction !== 2'd0) begin miscompares++; $display("FAIL t1_async_dir: got %0d want 0", direction); end
        vectors++; if (queue_count !== 3'd0) begin miscompares++; $display("FAIL t1_async_count: got %0d want 0", queue_count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t1_async_ovf: got %0d want 0", overflow); end
        KEY[0] = 1'b1;
        step(3);
        RESET = 1'b0;
        step(10);
        vectors++; if (queue_count !== 3'd0) begin miscompares++; $display("FAIL t1_post_count: got %0d want 0", queue_count); end
        press(0);
        vectors++; if (queue_count !== 3'd1) begin miscompares++; $display("FAIL t1_repress_count: got %0d want 1", queue_count); end
    endtask

    task automatic test_bounce();
        do_reset();
        KEY[0] = 1'b0; step(3);
        KEY[0] = 1'b1; step(1);
        KEY[0] = 1'b0; step(6);
        vectors++; if (queue_count !== 3'd0) begin miscompares++; $display("FAIL t2_count_at6: got %0d want 0", queue_count); end
        step(1);
        vectors++; if (queue_count !== 3'd1) begin miscompares++; $display("FAIL t2_count_at7: got %0d want 1", queue_count); end
        step(3);
        KEY[0] = 1'b1;
        step(10);
        vectors++; if (queue_count !== 3'd1) begin miscompares++; $display("FAIL t2_release_count: got %0d want 1", queue_count); end
        pulse_tick();
        vectors++; if (direction !== 2'd1) begin miscompares++; $display("FAIL t2_dir: got %0d want 1", direction); end
    endtask

    task automatic test_ticks();
        do_reset();
        press(0); press(0);
        vectors++; if (queue_count !== 3'd2) begin miscompares++; $display("FAIL t3_count0: got %0d want 2", queue_count); end
        pulse_tick();
        vectors++; if (direction !== 2'd1 || queue_count !== 3'd1) begin miscompares++; $display("FAIL t3_tick1: got dir %0d cnt %0d want 1 1", direction, queue_count); end
        pulse_tick();
        vectors++; if (direction !== 2'd2 || queue_count !== 3'd0) begin miscompares++; $display("FAIL t3_tick2: got dir %0d cnt %0d want 2 0", direction, queue_count); end
        pulse_tick();
        vectors++; if (direction !== 2'd2 || queue_count !== 3'd0) begin miscompares++; $display("FAIL t3_tick3: got dir %0d cnt %0d want 2 0", direction, queue_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        press(1);
        pulse_tick();
        vectors++; if (direction !== 2'd3) begin miscompares++; $display("FAIL t4_ccw_wrap: got %0d want 3", direction); end
        press(0);
        pulse_tick();
        vectors++; if (direction !== 2'd0) begin miscompares++; $display("FAIL t4_cw_wrap: got %0d want 0", direction); end
    endtask

    task automatic test_overflow();
        do_reset();
        press(0); press(0); press(0); press(0);
        vectors++; if (queue_count !== 3'd4 || overflow !== 1'b0) begin miscompares++; $display("FAIL t5_full: got cnt %0d ovf %0d want 4 0", queue_count, overflow); end
        press(0);
        vectors++; if (queue_count !== 3'd4 || overflow !== 1'b1) begin miscompares++; $display("FAIL t5_drop: got cnt %0d ovf %0d want 4 1", queue_count, overflow); end
        KEY[0] = 1'b0;
        step(6);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        vectors++; if (queue_count !== 3'd4 || direction !== 2'd1 || overflow !== 1'b1) begin miscompares++; $display("FAIL t5_push_pop: got cnt %0d dir %0d ovf %0d want 4 1 1", queue_count, direction, overflow); end
        KEY[0] = 1'b1;
        step(7);
        pulse_tick();
        vectors++; if (queue_count !== 3'd3 || direction !== 2'd2) begin miscompares++; $display("FAIL t5_pop: got cnt %0d dir %0d want 3 2", queue_count, direction); end
        enable = 1'b0;
        step(1);
        vectors++; if (overflow !== 1'b0 || queue_count !== 3'd0) begin miscompares++; $display("FAIL t5_disable: got ovf %0d cnt %0d want 0 0", overflow, queue_count); end
        enable = 1'b1;
        step(1);
    endtask

    task automatic test_cancel_and_disable();
        do_reset();
        press(0); press(0);
        pulse_tick(); pulse_tick();
        press(0); press(0); press(0);
        vectors++; if (queue_count !== 3'd3 || direction !== 2'd2) begin miscompares++; $display("FAIL t6_setup: got cnt %0d dir %0d want 3 2", queue_count, direction); end
        KEY = 2'b00;
        step(8);
        vectors++; if (queue_count !== 3'd3 || overflow !== 1'b0) begin miscompares++; $display("FAIL t6_cancel: got cnt %0d ovf %0d want 3 0", queue_count, overflow); end
        KEY = 2'b11;
        step(7);
        enable = 1'b0;
        step(1);
        vectors++; if (queue_count !== 3'd0 || direction !== 2'd0 || overflow !== 1'b0) begin miscompares++; $display("FAIL t6_flush: got cnt %0d dir %0d ovf %0d want 0 0 0", queue_count, direction, overflow); end
        pulse_tick();
        vectors++; if (direction !== 2'd0) begin miscompares++; $display("FAIL t6_tick_ignored: got %0d want 0", direction); end
        press(0);
        vectors++; if (queue_count !== 3'd0) begin miscompares++; $display("FAIL t6_press_ignored: got %0d want 0", queue_count); end
        KEY[0] = 1'b0;
        step(8);
        enable = 1'b1;
        step(8);
        vectors++; if (queue_count !== 3'd0) begin miscompares++; $display("FAIL t6_held_key: got %0d want 0", queue_count); end
        KEY[0] = 1'b1;
        step(7);
        press(0);
        vectors++; if (queue_count !== 3'd1) begin miscompares++; $display("FAIL t6_fresh_press: got %0d want 1", queue_count); end
        pulse_tick();
        vectors++; if (direction !== 2'd1) begin miscompares++; $display("FAIL t6_reenable_dir: got %0d want 1", direction); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_debounce();
        test_bounce();
        test_ticks();
        test_wrap();
        test_overflow();
        test_cancel_and_disable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
